// File: rtl/tdm_demux_two_to_one_if.sv
// Bus bundle for the two-channel TDM demultiplexer: interleaved sample in, two held channels out.
// i_in_valid qualifies i_d and i_frame; there is no ready, every valid sample is consumed the cycle it is presented.
interface tdm_demux_two_to_one_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] i_d;
  logic             i_in_valid;
  logic             i_frame;
  logic [WIDTH-1:0] o_y0;
  logic [WIDTH-1:0] o_y1;
  logic             o_v0;
  logic             o_v1;
  logic             o_locked;
  logic             o_frame_err;
  logic [CNT_W-1:0] o_frame_cnt;

  modport master (
    output i_d, i_in_valid, i_frame,
    input  o_y0, o_y1, o_v0, o_v1, o_locked, o_frame_err, o_frame_cnt
  );

  modport slave (
    input  i_d, i_in_valid, i_frame,
    output o_y0, o_y1, o_v0, o_v1, o_locked, o_frame_err, o_frame_cnt
  );
endinterface

// File: rtl/tdm_demux_two_to_one.sv
// Receive side of the two-channel TDM link: realigns on FRAME, splits slots into held
// channel outputs, flags slot-order errors, counts frames and drops lock after idle time.
module tdm_demux_two_to_one #(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  tdm_demux_two_to_one_if.slave  bus,
  output logic [1:0]             o_dbg_state
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_EXPECT1  = 2'd1,
    S_EXPECT0  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_y0;
  logic [WIDTH-1:0]   r_y1;
  logic [WIDTH-1:0]   w_y0_nxt;
  logic [WIDTH-1:0]   w_y1_nxt;
  logic               r_v0;
  logic               r_v1;
  logic               w_v0_nxt;
  logic               w_v1_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_locked;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDLE_W-1:0]  r_idle;
  logic [IDLE_W-1:0]  w_idle_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_UNLOCKED;
      r_y0     <= '0;
      r_y1     <= '0;
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
      r_cnt    <= '0;
      r_idle   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_y0     <= w_y0_nxt;
      r_y1     <= w_y1_nxt;
      r_v0     <= w_v0_nxt;
      r_v1     <= w_v1_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt != S_UNLOCKED);
      r_cnt    <= w_cnt_nxt;
      r_idle   <= w_idle_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y0_nxt    = r_y0;
    w_y1_nxt    = r_y1;
    w_v0_nxt    = 1'b0;
    w_v1_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;

    if (bus.i_in_valid) begin
      // A valid sample always restarts the idle window, even on the would-be timeout cycle.
      w_idle_nxt = '0;
      case (r_state)
        S_UNLOCKED: begin
          if (bus.i_frame) begin
            w_y0_nxt    = bus.i_d;
            w_v0_nxt    = 1'b1;
            w_state_nxt = S_EXPECT1;
          end
        end
        S_EXPECT1: begin
          if (bus.i_frame) begin
            // Early slot 0: report it, but resynchronise on it rather than losing lock.
            w_err_nxt = 1'b1;
            w_y0_nxt  = bus.i_d;
            w_v0_nxt  = 1'b1;
          end else begin
            w_y1_nxt    = bus.i_d;
            w_v1_nxt    = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = S_EXPECT0;
          end
        end
        S_EXPECT0: begin
          if (bus.i_frame) begin
            w_y0_nxt    = bus.i_d;
            w_v0_nxt    = 1'b1;
            w_state_nxt = S_EXPECT1;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_UNLOCKED;
          end
        end
        default: begin
          w_state_nxt = S_UNLOCKED;
        end
      endcase
    end else if (r_state != S_UNLOCKED) begin
      if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
        w_state_nxt = S_UNLOCKED;
        w_idle_nxt  = '0;
      end else begin
        w_idle_nxt = r_idle + 1'b1;
      end
    end
  end

  assign bus.o_y0        = r_y0;
  assign bus.o_y1        = r_y1;
  assign bus.o_v0        = r_v0;
  assign bus.o_v1        = r_v1;
  assign bus.o_locked    = r_locked;
  assign bus.o_frame_err = r_err;
  assign bus.o_frame_cnt = r_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_tdm_demux_two_to_one.sv
// Bench for tdm_demux_two_to_one: directed scenarios plus random traffic, all checked
// against a slot-tracking reference model every cycle.
module tb_tdm_demux_two_to_one;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       cmp_en;
  int         n_checks;
  int         n_fail;

  tdm_demux_two_to_one_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  tdm_demux_two_to_one #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: which slot is wanted next (-1 = not aligned)
  int         m_want;
  int         m_idle;
  int         m_cnt;
  logic [W-1:0] m_y0;
  logic [W-1:0] m_y1;
  logic       m_v0;
  logic       m_v1;
  logic       m_err;

  function automatic void model_reset();
    m_want = -1; m_idle = 0; m_cnt = 0;
    m_y0 = '0; m_y1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic f, input logic [W-1:0] dd);
    m_v0 = 1'b0; m_v1 = 1'b0; m_err = 1'b0;
    if (v) begin
      m_idle = 0;
      if (m_want < 0) begin
        if (f) begin m_y0 = dd; m_v0 = 1'b1; m_want = 1; end
      end else if (m_want == 1) begin
        if (f) begin m_err = 1'b1; m_y0 = dd; m_v0 = 1'b1; end
        else begin m_y1 = dd; m_v1 = 1'b1; m_cnt = (m_cnt + 1) % (1 << CW); m_want = 0; end
      end else begin
        if (f) begin m_y0 = dd; m_v0 = 1'b1; m_want = 1; end
        else begin m_err = 1'b1; m_want = -1; end
      end
    end else if (m_want >= 0) begin
      m_idle = m_idle + 1;
      if (m_idle >= TO) begin m_want = -1; m_idle = 0; end
    end
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("y0",        32'(bus.o_y0),        32'(m_y0));
      chk("y1",        32'(bus.o_y1),        32'(m_y1));
      chk("v0",        32'(bus.o_v0),        32'(m_v0));
      chk("v1",        32'(bus.o_v1),        32'(m_v1));
      chk("frame_err", 32'(bus.o_frame_err), 32'(m_err));
      chk("locked",    32'(bus.o_locked),    32'(m_want >= 0));
      chk("frame_cnt", 32'(bus.o_frame_cnt), 32'(m_cnt));
      chk("v_excl",    32'(bus.o_v0 & bus.o_v1), 32'd0);
    end
  end

  // driver
  task automatic step(input logic v, input logic f, input logic [W-1:0] dd);
    bus.i_in_valid = v;
    bus.i_frame    = f;
    bus.i_d        = dd;
    @(posedge clk);
    model_step(v, f, dd);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] y0, input logic [W-1:0] y1,
                          input logic v0, input logic v1, input logic err, input logic lk,
                          input logic [CW-1:0] cnt);
    chk({tag, ".y0"},  32'(bus.o_y0),        32'(y0));
    chk({tag, ".y1"},  32'(bus.o_y1),        32'(y1));
    chk({tag, ".v0"},  32'(bus.o_v0),        32'(v0));
    chk({tag, ".v1"},  32'(bus.o_v1),        32'(v1));
    chk({tag, ".err"}, 32'(bus.o_frame_err), 32'(err));
    chk({tag, ".lk"},  32'(bus.o_locked),    32'(lk));
    chk({tag, ".cnt"}, 32'(bus.o_frame_cnt), 32'(cnt));
  endtask

  initial begin
    logic stim_slot;
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_frame    = 1'b0;
    bus.i_d        = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk_outs("reset", 4'd0, 4'd0, 0, 0, 0, 0, 2'd0);

    // drop while unaligned, then acquire
    step(1, 0, 4'd5); chk_outs("drop",  4'd0, 4'd0, 0, 0, 0, 0, 2'd0);
    step(1, 1, 4'd6); chk_outs("acq",   4'd6, 4'd0, 1, 0, 0, 1, 2'd0);
    step(1, 0, 4'd9); chk_outs("slot1", 4'd6, 4'd9, 0, 1, 0, 1, 2'd1);
    step(1, 1, 4'd3); chk_outs("slot0", 4'd3, 4'd9, 1, 0, 0, 1, 2'd1);
    // early slot 0 while expecting slot 1
    step(1, 1, 4'd7); chk_outs("early", 4'd7, 4'd9, 1, 0, 1, 1, 2'd1);
    step(1, 0, 4'd2); chk_outs("resyn", 4'd7, 4'd2, 0, 1, 0, 1, 2'd2);
    // missing slot 0 while expecting slot 0
    step(1, 0, 4'd4); chk_outs("miss0", 4'd7, 4'd2, 0, 0, 1, 0, 2'd2);

    // idle timeout
    step(1, 1, 4'd1);
    step(1, 0, 4'd8);
    idle(TO - 1);     chk_outs("idle15", 4'd1, 4'd8, 0, 0, 0, 1, 2'd3);
    idle(1);          chk_outs("idle16", 4'd1, 4'd8, 0, 0, 0, 0, 2'd3);
    // sample arriving on the would-be timeout cycle keeps lock
    step(1, 1, 4'd2);
    step(1, 0, 4'd3); chk_outs("wrap0", 4'd2, 4'd3, 0, 1, 0, 1, 2'd0);
    idle(TO - 1);
    step(1, 1, 4'd4); chk_outs("save",  4'd4, 4'd3, 1, 0, 0, 1, 2'd0);

    // counter wrap from reset: 1,2,3,0,1
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, W'(k));
      step(1, 0, W'(k + 8));
      chk("wrap_cnt", 32'(bus.o_frame_cnt), 32'(k % 4));
    end
    // asynchronous reset between slot 0 and slot 1
    step(1, 1, 4'd9);
    chk("pre_rst_y0", 32'(bus.o_y0), 32'd9);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_outs("async", 4'd0, 4'd0, 0, 0, 0, 0, 2'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 0, 4'd5); chk_outs("post_rst", 4'd0, 4'd0, 0, 0, 0, 0, 2'd0);

    // random traffic
    stim_slot = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        idle($urandom_range(TO - 3, TO + 3));
      end else if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        logic f;
        f = (stim_slot == 1'b0);
        if ($urandom_range(0, 99) < 12) f = ~f;
        step(1'b1, f, W'($urandom_range(0, 15)));
        stim_slot = f ? 1'b1 : 1'b0;
      end
    end

    idle(2);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_two_to_one.md
Name: tdm_demux_two_to_one

Overview:
- Receiving end of the two-channel time-division link; the far end alternates two sources onto one wire through the two-to-one mux.
- Splits the interleaved sample stream back into two held channel outputs. Slot 0 is marked by FRAME.
- Tracks frame alignment, flags slot-order errors and counts completed frames.
- Sits between the link input register and the per-channel consumers.

Parameters:
- WIDTH, 1: sample width in bits, applies to D, Y0 and Y1.
- CNT_W, 8: width of FRAME_CNT.
- TIMEOUT, 16: idle cycles while locked, with no IN_VALID, before lock is dropped. Legal range is 2 or more.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- D  input  WIDTH  incoming interleaved sample.
- IN_VALID  input  1  D is valid this cycle.
- FRAME  input  1  qualifies the current valid sample as slot 0 (channel 0).
- Y0  output  WIDTH  last captured channel-0 sample, held between captures.
- Y1  output  WIDTH  last captured channel-1 sample, held between captures.
- V0  output  1  one-cycle pulse: Y0 updated this cycle.
- V1  output  1  one-cycle pulse: Y1 updated this cycle.
- LOCKED  output  1  frame alignment acquired.
- FRAME_ERR  output  1  one-cycle pulse: slot-order violation.
- FRAME_CNT  output  CNT_W  number of completed frames (slot 0 then slot 1).

Behaviour:
- Reset (RST_N low, asynchronous):
  - Y0, Y1 = 0; V0, V1, FRAME_ERR = 0; LOCKED = 0; FRAME_CNT = 0.
  - State = UNLOCKED; idle counter = 0.
  - Reset mid-frame discards any partial frame; the first valid sample after release is evaluated from UNLOCKED.
- All outputs are registered. The sample accepted on edge N appears on Y0/Y1 with its V pulse after edge N (1-cycle latency).
- Only cycles with IN_VALID=1 advance the state machine. IN_VALID=0 holds state, Y0 and Y1.
- State machine:
  - UNLOCKED, IN_VALID&FRAME: Y0<=D, V0=1, LOCKED<=1, go to EXPECT1.
  - UNLOCKED, IN_VALID&!FRAME: sample dropped, no error pulse, stay in UNLOCKED.
  - EXPECT1, IN_VALID&!FRAME: Y1<=D, V1=1, FRAME_CNT+1, go to EXPECT0.
  - EXPECT1, IN_VALID&FRAME: FRAME_ERR=1. The sample is treated as a new slot 0: Y0<=D, V0=1. Stay in EXPECT1; FRAME_CNT unchanged.
  - EXPECT0, IN_VALID&FRAME: Y0<=D, V0=1, go to EXPECT1.
  - EXPECT0, IN_VALID&!FRAME: FRAME_ERR=1, sample dropped, LOCKED<=0, go to UNLOCKED.
- FRAME is ignored when IN_VALID=0.
- FRAME_CNT wraps from 2^CNT_W-1 to 0 with no flag.
- V0 and V1 are never both high in the same cycle.
- Idle timeout:
  - The idle counter runs only while LOCKED=1, increments on each cycle with IN_VALID=0, and clears on IN_VALID=1.
  - When it reaches TIMEOUT: LOCKED<=0, state<=UNLOCKED, counter<=0. No FRAME_ERR pulse.
  - Y0 and Y1 keep their last values; FRAME_CNT is unchanged.
  - If IN_VALID=1 arrives in the same cycle the count would reach TIMEOUT, the sample wins: the counter clears and the sample is processed normally.
- Y0 and Y1 are never cleared except by reset.

Test Plan:
- Reset, then with WIDTH=4 send valid (D=3,FRAME=1), (D=9,FRAME=0) -> V0 pulse with Y0=3, next cycle V1 pulse with Y1=9, LOCKED=1, FRAME_CNT=1, FRAME_ERR never high.
- While UNLOCKED, send valid D=5,FRAME=0 -> no V pulse, no FRAME_ERR, Y0=Y1=0, LOCKED=0. Then D=6,FRAME=1 -> Y0=6, V0, LOCKED=1.
- Locked in EXPECT1, send D=7,FRAME=1 -> FRAME_ERR pulse, Y0=7, V0, still LOCKED. Next D=2,FRAME=0 -> Y1=2, FRAME_CNT increments.
- Locked in EXPECT0, send D=4,FRAME=0 -> FRAME_ERR pulse, LOCKED=0, Y0 and Y1 unchanged, no V pulse.
- After a complete frame, hold IN_VALID=0 for 16 cycles -> LOCKED falls after the 16th idle cycle, Y0/Y1/FRAME_CNT unchanged. Repeat with IN_VALID=1 on the 16th cycle -> LOCKED stays 1.
- With CNT_W=2, send 5 full frames -> FRAME_CNT sequence 1,2,3,0,1. Then assert RST_N=0 between slot 0 and slot 1 -> all outputs 0 immediately, without waiting for a clock edge.
